// File: rtl/tlm_mem_bridge.sv
// Bridge from decoded TLM generic-payload requests to a single-port word memory.
// Handles read, full write, and read-modify-write for partial byte enables.
module tlm_mem_bridge #(
    parameter  int unsigned MEM_DEPTH = 256,
    localparam int unsigned AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [1:0]    req_cmd_i,
    input  logic [31:0]   req_addr_i,
    input  logic [31:0]   req_data_i,
    input  logic [3:0]    req_be_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_data_o,
    output logic [1:0]    rsp_status_o,
    output logic          end_o,
    output logic [15:0]   txn_count_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    localparam logic [1:0] CMD_READ  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_END   = 2'd3;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_ADDR_ERR = 2'd1;
    localparam logic [1:0] ST_CMD_ERR  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR      = 3'd3,
        S_RESP    = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      cmd_q, cmd_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic [3:0]      be_q, be_d;
    logic            ready_q, ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic [1:0]      rsp_status_q, rsp_status_d;
    logic            end_q, end_d;
    logic [15:0]     txn_q, txn_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;

    logic            accept_c;
    logic            addr_err_c;
    logic            is_rw_c;
    logic [31:0]     merged_c;

    assign accept_c   = req_valid_i && ready_q;
    assign addr_err_c = (req_addr_i >> AW) != 32'd0;
    assign is_rw_c    = (req_cmd_i == CMD_READ) || (req_cmd_i == CMD_WRITE);

    // Byte merge for read-modify-write.
    always_comb begin
        merged_c = mem_rdata_i;
        for (int k = 0; k < 4; k++) begin
            if (be_q[k]) merged_c[8*k +: 8] = data_q[8*k +: 8];
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (is_rw_c && addr_err_c) begin
                        state_d = S_RESP;
                    end else if (req_cmd_i == CMD_READ) begin
                        state_d = S_RD;
                    end else if (req_cmd_i == CMD_WRITE) begin
                        if (req_be_i == 4'hF)      state_d = S_WR;
                        else if (req_be_i == 4'h0) state_d = S_RESP;
                        else                       state_d = S_RD;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RD:      state_d = S_RD_DATA;
            S_RD_DATA: state_d = (cmd_q == CMD_READ) ? S_RESP : S_WR;
            S_WR:      state_d = S_RESP;
            S_RESP:    if (rsp_ready_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values; every output lands in a register.
    always_comb begin
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        data_d       = data_q;
        be_d         = be_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        end_d        = end_q;
        txn_d        = txn_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    cmd_d        = req_cmd_i;
                    addr_d       = req_addr_i[AW-1:0];
                    data_d       = req_data_i;
                    be_d         = req_be_i;
                    rsp_data_d   = 32'd0;
                    rsp_status_d = ST_OK;
                    if (is_rw_c && addr_err_c) begin
                        rsp_status_d = ST_ADDR_ERR;
                    end else if (req_cmd_i == CMD_END) begin
                        end_d = 1'b1;
                    end else if (!is_rw_c) begin
                        rsp_status_d = ST_CMD_ERR;
                    end
                    if (state_d == S_RD) begin
                        mem_addr_d = req_addr_i[AW-1:0];
                    end else if (state_d == S_WR) begin
                        mem_addr_d  = req_addr_i[AW-1:0];
                        mem_we_d    = 1'b1;
                        mem_wdata_d = req_data_i;
                    end
                end
            end
            S_RD_DATA: begin
                if (cmd_q == CMD_READ) begin
                    rsp_data_d = mem_rdata_i;
                end else begin
                    mem_addr_d  = addr_q;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merged_c;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) txn_d = txn_q + 16'd1;
            end
            default: ;
        endcase
        rsp_valid_d = (state_d == S_RESP);
        ready_d     = (state_d == S_IDLE) && !end_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmd_q        <= 2'd0;
            addr_q       <= '0;
            data_q       <= 32'd0;
            be_q         <= 4'd0;
            ready_q      <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 32'd0;
            rsp_status_q <= 2'd0;
            end_q        <= 1'b0;
            txn_q        <= 16'd0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 32'd0;
        end else begin
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            be_q         <= be_d;
            ready_q      <= ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            end_q        <= end_d;
            txn_q        <= txn_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready_o  = ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_status_o = rsp_status_q;
    assign end_o        = end_q;
    assign txn_count_o  = txn_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_we_o     = mem_we_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_tlm_mem_bridge.sv
// Self-checking bench for tlm_mem_bridge: vector table with a response scoreboard,
// plus hand sequences for backpressure, mid-transaction reset and END_SIM.
module tb_tlm_mem_bridge;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_cmd = 2'd0;
    logic [31:0]   req_addr = 32'd0;
    logic [31:0]   req_data = 32'd0;
    logic [3:0]    req_be = 4'd0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_data;
    logic [1:0]    rsp_status;
    logic          end_sim;
    logic [15:0]   txn_count;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'd0;

    tlm_mem_bridge #(.MEM_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_cmd_i(req_cmd), .req_addr_i(req_addr), .req_data_i(req_data), .req_be_i(req_be),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_status_o(rsp_status),
        .end_o(end_sim), .txn_count_o(txn_count),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, whole-word write.
    logic [31:0] mem [DEPTH];
    int we_cnt = 0;
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt = we_cnt + 1;
        end
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp_data;
        logic [1:0]  exp_status;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  status;
        int          lat;
        int          we;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;
    int   model_txn = 0;
    int   we_base = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one request and return at the negedge right after the accept edge.
    task automatic issue(input vec_t v);
        exp_t e;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        chk("req_ready_before_issue", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_cmd   = v.cmd;
        req_addr  = v.addr;
        req_data  = v.data;
        req_be    = v.be;
        e.data    = v.exp_data;
        e.status  = v.exp_status;
        e.lat     = v.exp_lat;
        e.we      = (v.cmd == 2'd1 && v.addr < DEPTH && v.be != 4'h0) ? 1 : 0;
        sb.push_back(e);
        we_base = we_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_be    = 4'h0;
    endtask

    // Wait for rsp_valid (bounded) and score it against the queue head.
    task automatic collect();
        exp_t e;
        int   lat = 1;
        while (!rsp_valid && lat <= 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            sb.delete();
        end else if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_status", 32'(rsp_status), 32'(e.status));
            chk("rsp_latency", 32'(lat), 32'(e.lat));
            chk("mem_we_cycles", 32'(we_cnt - we_base), 32'(e.we));
        end
    endtask

    task automatic finish_rsp();
        @(posedge clk);
        @(negedge clk);
        model_txn = (model_txn + 1) & 16'hFFFF;
        chk("txn_count", 32'(txn_count), 32'(model_txn));
        chk("rsp_valid_dropped", 32'(rsp_valid), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_rsp_status"}, 32'(rsp_status), 32'd0);
        chk({tag, "_end"}, 32'(end_sim), 32'd0);
        chk({tag, "_txn"}, 32'(txn_count), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        logic [31:0] hold_data;
        logic [15:0] hold_txn;

        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'hC0DE0000 | 32'(i);
        mem[5] = 32'hAA000012;
        mem[9] = 32'hAABBCCDD;

        vecs.push_back('{2'd0, 32'd5,          32'h0,        4'h0, 32'hAA000012, 2'd0, 3});
        vecs.push_back('{2'd1, 32'd7,          32'h11223344, 4'hF, 32'h0,        2'd0, 2});
        vecs.push_back('{2'd0, 32'd7,          32'h0,        4'h0, 32'h11223344, 2'd0, 3});
        vecs.push_back('{2'd1, 32'd9,          32'h00112233, 4'h5, 32'h0,        2'd0, 4});
        vecs.push_back('{2'd0, 32'd9,          32'h0,        4'hA, 32'hAA11CC33, 2'd0, 3});
        vecs.push_back('{2'd0, 32'd256,        32'h0,        4'h0, 32'h0,        2'd1, 1});
        vecs.push_back('{2'd1, 32'h80000000,   32'hFFFFFFFF, 4'hF, 32'h0,        2'd1, 1});
        vecs.push_back('{2'd2, 32'd3,          32'h12345678, 4'hF, 32'h0,        2'd2, 1});
        vecs.push_back('{2'd2, 32'd300,        32'h0,        4'h0, 32'h0,        2'd2, 1});
        vecs.push_back('{2'd1, 32'd10,         32'hDEADBEEF, 4'h0, 32'h0,        2'd0, 1});
        vecs.push_back('{2'd0, 32'd10,         32'h0,        4'h0, 32'hC0DE000A, 2'd0, 3});
        vecs.push_back('{2'd1, 32'd255,        32'h12345678, 4'h8, 32'h0,        2'd0, 4});
        vecs.push_back('{2'd0, 32'd255,        32'h0,        4'h0, 32'h12DE00FF, 2'd0, 3});

        // Reset values.
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i]);
            collect();
            finish_rsp();
        end

        // Backpressure: response held for 10 cycles.
        rsp_ready = 1'b0;
        v = '{2'd0, 32'd7, 32'h0, 4'h0, 32'h11223344, 2'd0, 3};
        issue(v);
        collect();
        hold_data = rsp_data;
        hold_txn  = txn_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i % 3 == 0) begin
                chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("stall_rsp_data", rsp_data, 32'h11223344);
                chk("stall_req_ready", 32'(req_ready), 32'd0);
                chk("stall_txn", 32'(txn_count), 32'(hold_txn));
            end
        end
        chk("stall_data_held", rsp_data, hold_data);
        rsp_ready = 1'b1;
        finish_rsp();

        // Reset while a partial write sits in RD_DATA.
        v = '{2'd1, 32'd20, 32'hFFFFFFFF, 4'h3, 32'h0, 2'd0, 4};
        issue(v);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk_reset_vals("midrst");
        repeat (4) @(negedge clk);
        chk("midrst_word_unchanged", mem[20], 32'hC0DE0014);
        rst_n = 1'b1;
        model_txn = 0;
        repeat (3) @(negedge clk);
        chk("midrst_no_late_write", mem[20], 32'hC0DE0014);

        // END_SIM: OK response, sticky end, no further acceptance.
        v = '{2'd3, 32'd0, 32'h0, 4'h0, 32'h0, 2'd0, 1};
        issue(v);
        chk("end_set_on_accept", 32'(end_sim), 32'd1);
        collect();
        finish_rsp();
        req_valid = 1'b1;
        req_cmd   = 2'd0;
        req_addr  = 32'd5;
        repeat (5) @(negedge clk);
        chk("end_req_ready_low", 32'(req_ready), 32'd0);
        chk("end_sticky", 32'(end_sim), 32'd1);
        chk("end_no_rsp", 32'(rsp_valid), 32'd0);
        chk("end_txn_frozen", 32'(txn_count), 32'(model_txn));
        req_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tlm_mem_bridge.md
# tlm_mem_bridge

Synthesizable bridge between the SystemVerilog TLM target front end and the single-port word memory. Accepts one decoded generic-payload request at a time (command, word address, data, byte enables) over a valid/ready handshake, runs the memory access, including read-modify-write for partial byte enables, and returns data plus response status over a second valid/ready handshake. It sits directly upstream of the memory (registered read address, one-cycle read latency, whole-word write) and downstream of the DPI receive logic.

## Interface
- MEM_DEPTH, 256, memory depth in 32-bit words; power of two, ≥ 2
- AW, $clog2(MEM_DEPTH), memory address width (derived; not overridden)
- clk_i  input  1  clock; all state changes on posedge
- rst_n_i  input  1  asynchronous, active-low reset
- req_valid_i  input  1  request present
- req_ready_o  output  1  bridge can accept a request
- req_cmd_i  input  2  0 = READ, 1 = WRITE, 2 = IGNORE, 3 = END_SIM
- req_addr_i  input  32  word address
- req_data_i  input  32  write data, byte k = bits [8k+7:8k]
- req_be_i  input  4  byte enables for WRITE; ignored for READ
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  consumer takes response
- rsp_data_o  output  32  read data; 0 for non-READ and errored requests
- rsp_status_o  output  2  0 = OK, 1 = ADDRESS_ERROR, 2 = COMMAND_ERROR
- end_o  output  1  sticky END_SIM seen
- txn_count_o  output  16  completed responses, wraps at 16'hFFFF → 0
- mem_addr_o  output  AW  memory word address
- mem_we_o  output  1  memory write enable
- mem_wdata_o  output  32  memory write data
- mem_rdata_i  input  32  memory read data; valid one cycle after mem_addr_o is sampled

## Operation
- States: IDLE, RD, RD_DATA, WR, RESP.
- req_ready_o = (state == IDLE) && !end_o. It is registered-state only, with no combinational path from rsp_ready_i.
- In IDLE, a handshake (req_valid_i && req_ready_o) captures cmd, addr, data and be, then decodes:
  - addr ≥ MEM_DEPTH (any upper bit set) with READ or WRITE → RESP with ADDRESS_ERROR; no memory access.
  - cmd IGNORE → RESP, status COMMAND_ERROR.
  - cmd END_SIM → RESP, status OK; end_o set to 1 on the same edge.
  - READ → RD.
  - WRITE with be == 4'hF → WR, mem_wdata_o = captured data.
  - WRITE with be == 4'h0 → RESP, status OK; no memory access.
  - WRITE with partial be → RD (read-modify-write).
- RD: mem_addr_o = addr[AW-1:0], mem_we_o = 0. The next state is always RD_DATA.
- RD_DATA: sample mem_rdata_i.
  - READ: rsp_data ← mem_rdata_i, → RESP, OK.
  - Partial WRITE: merged byte k = be[k] ? data byte k : rdata byte k; → WR.
- WR: mem_addr_o = addr, mem_we_o = 1, mem_wdata_o = full or merged word for exactly one cycle; → RESP, OK.
- RESP: rsp_valid_o = 1. Data and status are held stable until rsp_ready_i. On the handshake edge: → IDLE and txn_count_o += 1.
- mem_we_o is 1 only in WR. mem_addr_o holds its last value outside RD and WR.
- end_o is cleared only by reset. Once set, no further requests are accepted.

## Timing
- Reset (async assert, sync release) values: state IDLE, req_ready_o 1, rsp_valid_o 0, rsp_data_o 0, rsp_status_o 0, end_o 0, txn_count_o 0, mem_addr_o 0, mem_we_o 0, mem_wdata_o 0.
- Latency from accept edge E0 to first cycle with rsp_valid_o = 1 (rsp_ready_i held 1):
  - error, IGNORE, END_SIM, or be == 0 write: after E0 (1 cycle)
  - full-word write: after E0+1 (2 cycles); the memory write occurs at E0+1
  - read: after E0+2 (3 cycles)
  - partial write: after E0+3 (4 cycles); the memory write occurs at E0+3
- Response handshake edge → IDLE. The next request can be accepted on the following edge, so the minimum period is latency + 1 cycle.
- Reset mid-transaction: the transaction is aborted with no response. A write that has not reached its WR edge never occurs.
- rsp_ready_i held low: the bridge stalls in RESP indefinitely, and req_ready_o stays 0.

## Test plan
- Reset, then READ addr 5 with memory word 5 = 32'hAA000012 → rsp_data_o 32'hAA000012, status OK, rsp_valid_o 3 cycles after accept, txn_count_o = 1.
- WRITE addr 7 data 32'h11223344 be 4'hF, then READ 7 → mem_we_o high for exactly 1 cycle; read returns 32'h11223344.
- Memory word 9 = 32'hAABBCCDD; WRITE addr 9 data 32'h00112233 be 4'b0101 → read back 32'hAA11CC33; write response 4 cycles after accept.
- READ addr 256 and WRITE addr 32'h80000000 → ADDRESS_ERROR, rsp_data_o 0, mem_we_o never asserted; cmd 2 → COMMAND_ERROR.
- rsp_ready_i low for 10 cycles during a READ → rsp_valid_o and rsp_data_o stable, req_ready_o 0; txn_count_o increments once on release.
- END_SIM → OK response, end_o = 1, req_ready_o stays 0. Assert rst_n_i during a partial write in RD_DATA → all outputs at reset values, target word unchanged.
